// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle sequencer: owns PC/IR, time-shares the single memory port between
// instruction fetch and data load/store/clear, and drives register bank and ULA control.
module sequenciador_multiciclo (
  input  logic        _clock,
  input  logic        _reset,
  input  logic [31:0] instrucao,
  input  logic [31:0] data,
  input  logic        mem_pronto,
  input  logic [31:0] dado1,
  input  logic [31:0] ula_result,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  fonte1,
  output logic [1:0]  id_reg,
  output logic        escrita,
  output logic [31:0] wb_dado,
  output logic [3:0]  ula_op,
  output logic [31:0] imediato,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [1:0] CTL_CLEAR = 2'b00;
  localparam logic [1:0] CTL_HCT   = 2'b01;
  localparam logic [1:0] CTL_LOAD  = 2'b10;
  localparam logic [1:0] CTL_STORE = 2'b11;

  state_t      state;
  logic [31:0] ir;
  logic        ir_mem_en;
  logic [1:0]  ir_mem_ctl;
  logic [3:0]  ir_ula_op;
  logic [1:0]  ir_reg;

  assign ir_mem_en  = ir[31];
  assign ir_mem_ctl = ir[30:29];
  assign ir_ula_op  = ir[28:25];
  assign ir_reg     = ir[24:23];
  assign imediato   = {{9{ir[22]}}, ir[22:0]};

  // Outputs are registered from the next state, so each state sees its own
  // request/enables from its first cycle; the port is free only in DECODE/EXEC/WB/HALT.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state     <= FETCH;
      ir        <= 32'd0;
      pc        <= 32'd0;
      retired   <= 16'd0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      escrita   <= 1'b0;
      fonte1    <= 2'd0;
      id_reg    <= 2'd0;
      wb_dado   <= 32'd0;
      ula_op    <= 4'd0;
    end else begin
      case (state)
        FETCH: begin
          // Right after reset the fetch request has not been presented yet.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_rw    <= 1'b0;
            mem_addr  <= pc;
            mem_wdata <= 32'd0;
          end else if (mem_pronto) begin
            ir      <= instrucao;
            pc      <= pc + 32'd1;
            fonte1  <= instrucao[24:23];
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (!ir_mem_en) begin
            ula_op <= ir_ula_op;
            state  <= EXEC;
          end else if (ir_mem_ctl == CTL_HCT) begin
            halted  <= 1'b1;
            retired <= retired + 16'd1;
            state   <= HALT;
          end else begin
            mem_req   <= 1'b1;
            mem_addr  <= imediato;
            mem_rw    <= (ir_mem_ctl != CTL_LOAD);
            mem_wdata <= (ir_mem_ctl == CTL_STORE) ? dado1 : 32'd0;
            state     <= MEM;
          end
        end
        EXEC: begin
          wb_dado <= ula_result;
          ula_op  <= 4'd0;
          id_reg  <= ir_reg;
          escrita <= 1'b1;
          state   <= WB;
        end
        MEM: begin
          if (mem_pronto) begin
            if (ir_mem_ctl == CTL_LOAD) begin
              wb_dado <= data;
              id_reg  <= ir_reg;
              escrita <= 1'b1;
              mem_req <= 1'b0;
              state   <= WB;
            end else begin
              retired   <= retired + 16'd1;
              mem_req   <= 1'b1;
              mem_rw    <= 1'b0;
              mem_addr  <= pc;
              mem_wdata <= 32'd0;
              state     <= FETCH;
            end
          end
        end
        WB: begin
          escrita   <= 1'b0;
          retired   <= retired + 16'd1;
          mem_req   <= 1'b1;
          mem_rw    <= 1'b0;
          mem_addr  <= pc;
          mem_wdata <= 32'd0;
          state     <= FETCH;
        end
        HALT: begin
          mem_req <= 1'b0;
          escrita <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Scoreboard bench for sequenciador_multiciclo: a memory responder and register/ULA
// models drive the DUT; a monitor checks every memory handshake and write-back.
module tb_sequenciador_multiciclo;

  logic        _clock;
  logic        _reset;
  logic [31:0] instrucao;
  logic [31:0] data;
  logic        mem_pronto;
  logic [31:0] dado1;
  logic [31:0] ula_result;
  logic [31:0] pc;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  fonte1;
  logic [1:0]  id_reg;
  logic        escrita;
  logic [31:0] wb_dado;
  logic [3:0]  ula_op;
  logic [31:0] imediato;
  logic        halted;
  logic [15:0] retired;

  sequenciador_multiciclo dut (
    ._clock(_clock), ._reset(_reset), .instrucao(instrucao), .data(data),
    .mem_pronto(mem_pronto), .dado1(dado1), .ula_result(ula_result), .pc(pc),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fonte1(fonte1), .id_reg(id_reg), .escrita(escrita), .wb_dado(wb_dado),
    .ula_op(ula_op), .imediato(imediato), .halted(halted), .retired(retired)
  );

  typedef struct {
    bit          is_mem;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [1:0]  wreg;
    logic [31:0] wval;
    int          gap;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_evt = 0;
  bit   force_pronto = 1'b0;

  initial begin
    _clock = 1'b0;
    forever #5 _clock = ~_clock;
  end

  always @(posedge _clock) cyc <= cyc + 1;

  always_comb begin
    case (fonte1)
      2'd0:    dado1 = 32'h0000_0100;
      2'd1:    dado1 = 32'h0000_0200;
      2'd2:    dado1 = 32'h0000_ABCD;
      default: dado1 = 32'h0000_0400;
    endcase
  end

  always_comb begin
    ula_result = (ula_op == 4'd3) ? dado1 + imediato : {28'hDEAD000, ula_op};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [31:0] instr, input int gap);
    exp_t e;
    e.is_mem = 1'b1; e.rw = 1'b0; e.addr = addr; e.wdata = 32'd0; e.rdata = instr;
    e.waits = 0; e.wreg = 2'd0; e.wval = 32'd0; e.gap = gap; e.name = "fetch";
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input int gap,
                          input string name);
    exp_t e;
    e.is_mem = 1'b1; e.rw = rw; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.waits = waits; e.wreg = 2'd0; e.wval = 32'd0; e.gap = gap; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_wb(input logic [1:0] wreg, input logic [31:0] wval, input int gap,
                         input string name);
    exp_t e;
    e.is_mem = 1'b0; e.rw = 1'b0; e.addr = 32'd0; e.wdata = 32'd0; e.rdata = 32'd0;
    e.waits = 0; e.wreg = wreg; e.wval = wval; e.gap = gap; e.name = name;
    exp_q.push_back(e);
  endtask

  // Memory responder: serves the request at the head of the queue after its wait cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_pronto = 1'b0;
    instrucao = 32'd0;
    data = 32'd0;
    forever begin
      @(posedge _clock);
      #1;
      if (force_pronto) begin
        mem_pronto = 1'b1;
      end else if (_reset || !mem_req || exp_q.size() == 0 || !exp_q[0].is_mem) begin
        mem_pronto = 1'b0;
        wcnt = 0;
      end else if (wcnt < exp_q[0].waits) begin
        mem_pronto = 1'b0;
        wcnt++;
      end else begin
        mem_pronto = 1'b1;
        instrucao = exp_q[0].rdata;
        data = exp_q[0].rdata;
        wcnt = 0;
      end
    end
  end

  // Monitor: compares every presented request and write-back against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge _clock);
      if (!_reset) begin
        if (mem_req && escrita) chk("req_and_write_overlap", 64'd1, 64'd0);
        if (mem_req) begin
          if (exp_q.size() == 0 || !exp_q[0].is_mem) begin
            chk("unexpected_mem_req", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q[0];
            chk({e.name, "_addr_rw"}, {31'd0, mem_rw, mem_addr}, {31'd0, e.rw, e.addr});
            if (e.rw) chk({e.name, "_wdata"}, {32'd0, mem_wdata}, {32'd0, e.wdata});
            if (mem_pronto) begin
              if (e.gap >= 0) chk({e.name, "_latency"}, 64'(cyc - last_evt), 64'(e.gap));
              last_evt = cyc;
              void'(exp_q.pop_front());
            end
          end
        end
        if (escrita) begin
          if (exp_q.size() == 0 || exp_q[0].is_mem) begin
            chk("unexpected_escrita", {30'd0, id_reg, wb_dado}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q[0];
            chk({e.name, "_reg_data"}, {30'd0, id_reg, wb_dado}, {30'd0, e.wreg, e.wval});
            if (e.gap >= 0) chk({e.name, "_latency"}, 64'(cyc - last_evt), 64'(e.gap));
            last_evt = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int reqs;
    _reset = 1'b1;
    repeat (3) @(negedge _clock);
    chk("reset_pc", {32'd0, pc}, 64'd0);
    chk("reset_ctrl", {60'd0, mem_req, mem_rw, escrita, halted}, 64'd0);
    chk("reset_retired", {48'd0, retired}, 64'd0);
    chk("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);

    // arith r0 = r0 + 5 ; load r1 <- [16] with 2 waits ; store r2 -> [-1] ; store r3 -> [0x20] (never completes)
    push_fetch(32'd0, 32'h0600_0005, -1);
    push_wb(2'd0, 32'h0000_0105, 3, "arith_wb");
    push_fetch(32'd1, 32'hC080_0010, 1);
    push_mem(1'b0, 32'd16, 32'd0, 32'h1234_5678, 2, 4, "load");
    push_wb(2'd1, 32'h1234_5678, 1, "load_wb");
    push_fetch(32'd2, 32'hE17F_FFFF, 1);
    push_mem(1'b1, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'd0, 0, 2, "store");
    push_fetch(32'd3, 32'hE180_0020, 1);
    push_mem(1'b1, 32'h0000_0020, 32'h0000_0400, 32'd0, 1000, -1, "store_abort");

    _reset = 1'b0;
    chk("first_req_before_edge", {63'd0, mem_req}, 64'd0);
    @(posedge _clock);
    #1;
    chk("first_req_after_edge", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'd0});

    n = 0;
    while (!(mem_req && mem_rw && mem_addr == 32'h20) && n < 100) begin
      @(negedge _clock);
      n++;
    end
    chk("store_abort_reached", {63'd0, n < 100}, 64'd1);
    chk("pc_after_four_fetches", {32'd0, pc}, 64'd4);
    chk("retired_after_three", {48'd0, retired}, 64'd3);

    repeat (2) @(negedge _clock);
    #2 _reset = 1'b1;
    #1;
    chk("abort_pc_retired", {pc, 16'd0, retired}, 64'd0);
    chk("abort_mem_ctrl", {60'd0, mem_req, mem_rw, escrita, halted}, 64'd0);
    chk("abort_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    chk("abort_wb", {22'd0, fonte1, id_reg, ula_op, wb_dado}, 64'd0);
    chk("abort_imediato", {32'd0, imediato}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge _clock);

    // clear [7] ; HCT
    push_fetch(32'd0, 32'h8000_0007, -1);
    push_mem(1'b1, 32'd7, 32'd0, 32'd0, 0, 2, "clear");
    push_fetch(32'd1, 32'hA000_0000, 1);
    _reset = 1'b0;

    n = 0;
    while (!halted && n < 50) begin
      @(negedge _clock);
      n++;
    end
    chk("halt_reached", {63'd0, n < 50}, 64'd1);
    chk("halt_retired", {48'd0, retired}, 64'd2);
    chk("halt_pc", {32'd0, pc}, 64'd2);
    chk("halt_queue_drained", 64'(exp_q.size()), 64'd0);

    force_pronto = 1'b1;
    reqs = 0;
    repeat (20) begin
      @(negedge _clock);
      if (mem_req || escrita || !halted) reqs++;
    end
    chk("halt_sticky_no_req", 64'(reqs), 64'd0);
    chk("halt_retired_stable", {48'd0, retired}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
